// File: rtl/riscv_core_icache_pkg.sv
// rtl/riscv_core_icache_pkg.sv - shared state type, constants and line-address helper for the icache controller
package riscv_core_icache_pkg;

  localparam int MAX_WAYS = 8;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    REFILL,
    FLUSH
  } icache_state_e;

  function automatic logic [63:0] line_addr(input logic [63:0] addr, input int offset_width);
    logic [63:0] mask;
    mask = ~64'd0 << offset_width;
    return addr & mask;
  endfunction

endpackage

// File: rtl/riscv_core_icache_plru.sv
// rtl/riscv_core_icache_plru.sv - tree pseudo-LRU state for every set; node bit 0 points left, 1 points right
module riscv_core_icache_plru
  import riscv_core_icache_pkg::*;
#(
  parameter int NUM_WAYS    = 2,
  parameter int INDEX_WIDTH = 7,
  localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   touch_en,
  input  logic [INDEX_WIDTH-1:0] touch_idx,
  input  logic [WAY_W-1:0]       touch_way,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic [WAY_W-1:0]       victim_way,
  input  logic                   clear_all
);

  localparam int SETS = 1 << INDEX_WIDTH;

  if (NUM_WAYS == 1) begin : g_direct
    assign victim_way = '0;
  end else begin : g_tree
    localparam int LEVELS = $clog2(NUM_WAYS);
    localparam int NODES  = NUM_WAYS - 1;

    logic [NODES-1:0] tree_q [SETS];
    logic [NODES-1:0] tree_upd;
    logic [WAY_W-1:0] vict;

    // Walk root to leaf, pointing every node on the path away from the touched way.
    always_comb begin
      int node;
      tree_upd = tree_q[touch_idx];
      node     = 1;
      for (int l = 0; l < LEVELS; l++) begin
        tree_upd[node-1] = ~touch_way[LEVELS-1-l];
        node             = 2 * node + int'(touch_way[LEVELS-1-l]);
      end
    end

    always_comb begin
      int   node;
      logic b;
      vict = '0;
      node = 1;
      b    = 1'b0;
      for (int l = 0; l < LEVELS; l++) begin
        b                  = tree_q[rd_idx][node-1];
        vict[LEVELS-1-l]   = b;
        node               = 2 * node + int'(b);
      end
    end

    assign victim_way = vict;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
      end else if (clear_all) begin
        for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
      end else if (touch_en) begin
        tree_q[touch_idx] <= tree_upd;
      end
    end
  end

endmodule

// File: rtl/riscv_core_icache_assoc_controller.sv
// rtl/riscv_core_icache_assoc_controller.sv - N-way icache tag/valid lookup, refill and FENCE.I flush control
// ICACHE_PERF_CNT_EN adds o_hit_cnt/o_miss_cnt outputs.
module riscv_core_icache_assoc_controller
  import riscv_core_icache_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 5,
  parameter int NUM_WAYS     = 2,
  localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int WAY_W       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_rd_en,
  output logic [WAY_W-1:0]      o_hit_way,
  output logic                  o_wr_en,
  output logic [WAY_W-1:0]      o_wr_way,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_req,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]           o_hit_cnt,
  output logic [31:0]           o_miss_cnt,
`endif
  input  logic                  i_mem_done
);

  localparam int SETS = 1 << INDEX_WIDTH;

  icache_state_e state_q, state_d;

  logic [TAG_WIDTH-1:0]   tag_q [NUM_WAYS][SETS];
  logic [SETS-1:0]        valid_q [NUM_WAYS];
  logic [WAY_W-1:0]       victim_q, victim_c, plru_victim, hit_way_c, touch_way;
  logic                   pend_q, pend_d;
  logic                   hit_c, touch_en, clear_all, victim_load;
  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag;

  assign idx        = i_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag        = i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign o_mem_addr = ADDR_WIDTH'(line_addr(64'(i_addr), OFFSET_WIDTH));

  riscv_core_icache_plru #(
    .NUM_WAYS    (NUM_WAYS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_plru (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .touch_en   (touch_en),
    .touch_idx  (idx),
    .touch_way  (touch_way),
    .rd_idx     (idx),
    .victim_way (plru_victim),
    .clear_all  (clear_all)
  );

  // Descending scan so the lowest-index invalid way is the one left standing.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    victim_c  = plru_victim;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) victim_c = WAY_W'(w);
    end
  end

  // Outputs are gated by reset so strobes drop the instant i_rst_n falls.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    o_stall     = 1'b0;
    o_rd_en     = 1'b0;
    o_hit_way   = '0;
    o_wr_en     = 1'b0;
    o_wr_way    = '0;
    o_mem_req   = 1'b0;
    touch_en    = 1'b0;
    touch_way   = '0;
    clear_all   = 1'b0;
    victim_load = 1'b0;
    if (i_rst_n) begin
      case (state_q)
        IDLE: begin
          if (i_flush) begin
            state_d = FLUSH;
          end else if (i_req) begin
            if (hit_c) begin
              o_rd_en   = 1'b1;
              o_hit_way = hit_way_c;
              touch_en  = 1'b1;
              touch_way = hit_way_c;
            end else begin
              o_stall     = 1'b1;
              o_mem_req   = 1'b1;
              victim_load = 1'b1;
              state_d     = MEM_REQ;
            end
          end
        end
        MEM_REQ: begin
          o_stall = 1'b1;
          if (i_flush) pend_d = 1'b1;
          if (i_mem_done) state_d = REFILL;
          else            o_mem_req = 1'b1;
        end
        REFILL: begin
          o_stall   = 1'b1;
          o_wr_en   = 1'b1;
          o_wr_way  = victim_q;
          touch_en  = 1'b1;
          touch_way = victim_q;
          state_d   = (pend_q || i_flush) ? FLUSH : IDLE;
        end
        FLUSH: begin
          o_stall   = 1'b1;
          clear_all = 1'b1;
          pend_d    = 1'b0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      victim_q <= '0;
      for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (victim_load) victim_q <= victim_c;
      if (clear_all) begin
        for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
      end else if (o_wr_en) begin
        valid_q[victim_q][idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (o_wr_en) tag_q[victim_q][idx] <= tag;
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (o_rd_en) o_hit_cnt <= o_hit_cnt + 32'd1;
      if (state_q == IDLE && o_mem_req) o_miss_cnt <= o_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_core_icache_assoc_controller.sv
// tb/tb_riscv_core_icache_assoc_controller.sv - randomized fetch/flush/refill bench against an LRU reference model
module tb_riscv_core_icache_assoc_controller;

  logic        clk = 1'b0;
  logic        rst_n, req, flush, mem_done;
  logic [63:0] addr, mem_addr;
  logic        stall, rd_en, hit_way, wr_en, wr_way, mem_req;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int n_hit = 0;
  int n_miss = 0;

  bit          m_valid [2][128];
  logic [51:0] m_tag   [2][128];
  int unsigned m_use   [2][128];
  int unsigned m_time = 0;

  always #5 clk = ~clk;

  riscv_core_icache_assoc_controller dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_addr     (addr),
    .i_flush    (flush),
    .o_stall    (stall),
    .o_rd_en    (rd_en),
    .o_hit_way  (hit_way),
    .o_wr_en    (wr_en),
    .o_wr_way   (wr_way),
    .o_mem_addr (mem_addr),
    .o_mem_req  (mem_req),
`ifdef ICACHE_PERF_CNT_EN
    .o_hit_cnt  (hit_cnt),
    .o_miss_cnt (miss_cnt),
`endif
    .i_mem_done (mem_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_clear();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 128; s++) m_valid[w][s] = 1'b0;
  endfunction

  function automatic void m_touch(input int s, input int w);
    m_time++;
    m_use[w][s] = m_time;
  endfunction

  function automatic int m_lookup(input int s, input logic [51:0] t);
    for (int w = 0; w < 2; w++)
      if (m_valid[w][s] && m_tag[w][s] == t) return w;
    return -1;
  endfunction

  // Invalid ways first, then least recently used (tree PLRU is exact LRU at 2 ways).
  function automatic int m_victim(input int s);
    for (int w = 0; w < 2; w++)
      if (!m_valid[w][s]) return w;
    return (m_use[0][s] < m_use[1][s]) ? 0 : 1;
  endfunction

  // fl: 0 no flush, 1 flush pulse in first MEM_REQ cycle, 2 flush pulse in REFILL
  task automatic do_fetch(input logic [63:0] a, input int lat, input int fl);
    int          s, w, v;
    logic [51:0] t;
    s = int'(a[11:5]);
    t = a[63:12];
    w = m_lookup(s, t);
    req = 1'b1; addr = a; mem_done = 1'($urandom_range(0, 1));
    #2;
    check("lookup_stall", stall, (w < 0));
    check("lookup_mem_addr", mem_addr, a & ~64'h1f);
    if (w >= 0) begin
      check("hit_rd_en", rd_en, 1);
      check("hit_way", hit_way, 64'(w));
      check("hit_wr_way_zero", wr_way, 0);
      check("hit_mem_req", mem_req, 0);
      m_touch(s, w);
      n_hit++;
      tick();
      req = 1'b0; mem_done = 1'b0;
    end else begin
      check("miss_mem_req", mem_req, 1);
      check("miss_rd_en", rd_en, 0);
      check("miss_hit_way_zero", hit_way, 0);
      v = m_victim(s);
      n_miss++;
      tick();
      for (int k = 1; k <= lat; k++) begin
        mem_done = (k == lat);
        flush = (fl == 1) && (k == 1);
        #2;
        check("mr_stall", stall, 1);
        check("mr_mem_req", mem_req, (k != lat));
        check("mr_wr_en", wr_en, 0);
        tick();
      end
      mem_done = 1'b0;
      flush = (fl == 2);
      #2;
      check("rf_wr_en", wr_en, 1);
      check("rf_wr_way", wr_way, 64'(v));
      check("rf_stall", stall, 1);
      check("rf_mem_req", mem_req, 0);
      m_valid[v][s] = 1'b1;
      m_tag[v][s] = t;
      m_touch(s, v);
      tick();
      flush = 1'b0;
      if (fl != 0) begin
        req = 1'b0;
        #2;
        check("pend_flush_stall", stall, 1);
        check("pend_flush_wr_en", wr_en, 0);
        m_clear();
        tick();
      end else begin
        #2;
        check("post_rd_en", rd_en, 1);
        check("post_hit_way", hit_way, 64'(v));
        check("post_stall", stall, 0);
        m_touch(s, v);
        n_hit++;
        tick();
        req = 1'b0;
      end
    end
  endtask

  task automatic do_flush();
    req = 1'b0; flush = 1'b1; mem_done = 1'($urandom_range(0, 1));
    #2;
    check("flush_pulse_stall", stall, 0);
    check("flush_pulse_rd_en", rd_en, 0);
    check("flush_pulse_mem_req", mem_req, 0);
    tick();
    flush = 1'b0; mem_done = 1'b0;
    #2;
    check("flush_stall", stall, 1);
    tick();
    m_clear();
    #2;
    check("flush_after_stall", stall, 0);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = (64'($urandom_range(1, 4)) << 12) | (64'($urandom_range(0, 2)) << 5) | 64'($urandom_range(0, 31));
    if ($urandom_range(0, 1) == 1) a[63] = 1'b1;
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b1; flush = 1'b0; mem_done = 1'b0; addr = 64'h1000;
    m_clear();
    #2;
    check("rst_stall", stall, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_hit_way", hit_way, 0);
    check("rst_wr_way", wr_way, 0);
    req = 1'b0;
    tick();
    rst_n = 1'b1;

    do_fetch(64'h1000, 4, 0);
    do_fetch(64'h2000, 2, 0);
    do_fetch(64'h1000, 1, 0);
    do_fetch(64'h2004, 1, 0);
    do_fetch(64'h1000, 1, 0);
    do_fetch(64'h3000, 1, 0);
    do_fetch(64'h1000, 1, 0);
    do_fetch(64'h2000, 3, 0);
    do_flush();
    do_fetch(64'h1000, 2, 0);
    do_fetch(64'h5000, 2, 1);
    do_fetch(64'h5000, 1, 0);
    do_fetch(64'h6020, 1, 2);

    req = 1'b1; addr = 64'h7000;
    tick();
    #2;
    check("rst_mid_mem_req_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_stall", stall, 0);
    req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_clear();
    n_hit = 0; n_miss = 0;
    do_fetch(64'h1000, 2, 0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 19))
        0:       do_flush();
        1: begin
          req = 1'b0; mem_done = 1'($urandom_range(0, 1));
          #2;
          check("idle_stall", stall, 0);
          tick();
          mem_done = 1'b0;
        end
        default: do_fetch(rand_addr(), $urandom_range(1, 4),
                          ($urandom_range(0, 14) == 0) ? $urandom_range(1, 2) : 0);
      endcase
    end

`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt", 64'(hit_cnt), 64'(n_hit));
    check("miss_cnt", 64'(miss_cnt), 64'(n_miss));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_core_icache_assoc_controller.md
# riscv_core_icache_assoc_controller

Parametrised N-way set-associative instruction-cache controller for the RV64IMAC fetch path. It holds per-way tag and valid arrays and performs the tag lookup. On a miss it stalls the core, requests a line refill from the AXI master, and picks the victim way with tree pseudo-LRU. It also supports a whole-cache invalidate for FENCE.I. It drives the way-banked cache data memory and sits between the fetch stage, the icache data array and the AXI refill module.

## Interface
- ADDR_WIDTH, 64, fetch address width
- INDEX_WIDTH, 7, set index bits (sets = 2**INDEX_WIDTH)
- OFFSET_WIDTH, 5, line byte-offset bits (32-byte line)
- NUM_WAYS, 2, associativity; power of two, 1..8
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH, derived; do not override

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low; clock is i_clk
- i_req  in  1  fetch valid
- i_addr  in  ADDR_WIDTH  fetch address; core holds it stable while o_stall=1
- i_flush  in  1  invalidate whole cache (FENCE.I), single-cycle pulse
- o_stall  out  1  hold fetch
- o_rd_en  out  1  read data array, hit way
- o_hit_way  out  $clog2(NUM_WAYS) (min 1)  way hit on this lookup
- o_wr_en  out  1  write refill line into the data array
- o_wr_way  out  $clog2(NUM_WAYS) (min 1)  way being refilled
- o_mem_addr  out  ADDR_WIDTH  {tag,index,OFFSET_WIDTH'b0}
- o_mem_req  out  1  refill request to AXI
- i_mem_done  in  1  refill line available, one-cycle pulse

## Operation
- FSM states: IDLE, MEM_REQ, REFILL, FLUSH.
- IDLE transitions:
  - i_flush has priority over lookup → FLUSH, o_stall=1.
  - Else if i_req=1, the lookup compares all ways in parallel.
  - Hit: o_rd_en=1, o_hit_way=matching way, PLRU updated; stay in IDLE.
  - Miss: o_stall=1, o_mem_req=1, victim latched, → MEM_REQ.
- Victim choice: lowest-index invalid way, else the PLRU victim. With NUM_WAYS=1 the victim is always way 0.
- MEM_REQ: o_stall=1, o_mem_req=1 until i_mem_done. On i_mem_done, o_mem_req=0 in that same cycle, → REFILL.
- REFILL: o_wr_en=1, o_wr_way=latched victim, o_stall=1. Tag and valid are written and PLRU marks the victim most-recent. → FLUSH if a flush is pending, else IDLE.
- FLUSH: clears every valid bit and all PLRU bits in one cycle, o_stall=1, → IDLE.
- i_flush during MEM_REQ or REFILL sets a pending bit; the refill completes first, then FLUSH runs.
- i_mem_done outside MEM_REQ is ignored.
- Two ways never hold the same tag in one set. A simultaneous multi-way match is impossible by construction and needs no handling.
- Multi-bit outputs are 0 whenever their qualifying strobe is 0, except o_mem_addr, which is always the aligned i_addr.

## Timing
- Reset (asynchronous): state=IDLE, all valid=0, PLRU=0, flush-pending=0. o_stall, o_rd_en, o_wr_en and o_mem_req=0 immediately; o_hit_way and o_wr_way=0.
- Reset asserted mid-MEM_REQ drops o_mem_req in the same instant.
- Hit latency is 0: combinational in the request cycle, no stall.
- Miss: o_stall asserts in cycle 0. The hit is returned at L+2 cycles, where L is the number of MEM_REQ cycles up to and including i_mem_done.
- Flush costs 1 stall cycle from IDLE.
- Tag, valid and PLRU state update on the rising edge at the end of the hit, REFILL or FLUSH cycle.

## Configuration
- ICACHE_PERF_CNT_EN:
  - Defined: adds output ports o_hit_cnt[31:0] and o_miss_cnt[31:0]. They increment on each IDLE hit and each IDLE miss respectively, wrap at 2**32, and reset to 0. i_flush does not clear them.
  - Undefined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Package riscv_core_icache_pkg holds:
  - the state enum icache_state_e;
  - a line-address helper function;
  - the constant MAX_WAYS=8.
- Sub-module riscv_core_icache_plru holds the tree PLRU for one set array. It is parametrised by NUM_WAYS and INDEX_WIDTH and has ports: touch index/way, read victim index, clear-all.

## Test plan
- Reset, then fetch 0x1000 → o_stall=1, o_mem_req=1, o_mem_addr=0x1000. i_mem_done at cycle 4 → REFILL with o_wr_en=1, o_wr_way=0; cycle 6 gives o_rd_en=1, o_hit_way=0, o_stall=0.
- Fill 0x1000 then 0x2000 (both set 0, NUM_WAYS=2) → 0x2000 lands in way 1; both then hit with no stall.
- Fill 0x1000 and 0x2000, hit 0x1000, fetch 0x3000 → victim way 1. Then 0x1000 hits way 0; 0x2000 misses.
- With 0x1000 cached, pulse i_flush → exactly one cycle with o_stall=1; a following 0x1000 fetch misses.
- Pulse i_flush during MEM_REQ → REFILL completes, then FLUSH, and the refilled 0x1000 misses afterward.
- Assert i_rst_n=0 during MEM_REQ → o_mem_req=0 at once, and 0x1000 misses after release. With ICACHE_PERF_CNT_EN, 3 misses and 5 hits → o_miss_cnt=3, o_hit_cnt=5.
